// File: rtl/rate_enable_gen_if.sv
// Signal bundle for rate_enable_gen: Run/Speed in, Enable/Running out, plus a debug FSM state bit.
// With RATE_STEP_EN defined the bundle also carries the Step pushbutton input.
interface rate_enable_gen_if;
  logic       Run;
  logic [1:0] Speed;
  logic       Enable;
  logic       Running;
  logic       State;     // debug: 0 = IDLE, 1 = COUNT
`ifdef RATE_STEP_EN
  logic       Step;
`endif

  // Handshake: none. Run and Speed are levels sampled on every posedge;
  // Enable is a registered single-cycle pulse and is never held off by a ready.
`ifdef RATE_STEP_EN
  modport master (output Run, Speed, Step, input Enable, Running, State);
  modport slave  (input Run, Speed, Step, output Enable, Running, State);
`else
  modport master (output Run, Speed, input Enable, Running, State);
  modport slave  (input Run, Speed, output Enable, Running, State);
`endif
endinterface

// File: rtl/rate_enable_gen.sv
// Paced Enable pulse generator: down-counter divider with an IDLE/COUNT FSM, rate chosen by Speed.
// Optional macro RATE_STEP_EN adds a synchronized Step pushbutton for single-step pulses in IDLE.
module rate_enable_gen #(
  parameter int DIV_1 = 50_000_000,
  parameter int DIV_2 = 100_000_000,
  parameter int DIV_3 = 200_000_000,
  parameter int WIDTH = 28
) (
  input  logic           Clock,
  input  logic           Resetn,
  rate_enable_gen_if.slave bus
);

  typedef enum logic {ST_IDLE = 1'b0, ST_COUNT = 1'b1} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [1:0]       r_speed;
  logic             r_enable;
  logic             r_running;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic [1:0]       w_speed_nxt;
  logic             w_enable_nxt;
  logic             w_running_nxt;
  logic             w_step_rise;

  // Reload value is DIV-1 so a pulse lands exactly every DIV cycles.
  function automatic logic [WIDTH-1:0] div_m1(input logic [1:0] s);
    case (s)
      2'b01:   div_m1 = WIDTH'(DIV_1 - 1);
      2'b10:   div_m1 = WIDTH'(DIV_2 - 1);
      2'b11:   div_m1 = WIDTH'(DIV_3 - 1);
      default: div_m1 = '0;
    endcase
  endfunction

`ifdef RATE_STEP_EN
  logic r_step_s1;
  logic r_step_s2;
  logic r_step_prev;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_step_s1   <= 1'b0;
      r_step_s2   <= 1'b0;
      r_step_prev <= 1'b0;
    end else begin
      r_step_s1   <= bus.Step;
      r_step_s2   <= r_step_s1;
      r_step_prev <= r_step_s2;
    end
  end

  assign w_step_rise = r_step_s2 & ~r_step_prev;
`else
  assign w_step_rise = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_speed_nxt   = r_speed;
    w_enable_nxt  = 1'b0;
    w_running_nxt = r_running;
    case (r_state)
      ST_IDLE: begin
        if (bus.Run) begin
          w_count_nxt   = div_m1(bus.Speed);
          w_speed_nxt   = bus.Speed;
          w_state_nxt   = ST_COUNT;
          w_running_nxt = 1'b1;
        end else if (w_step_rise) begin
          w_enable_nxt = 1'b1;
        end
      end
      ST_COUNT: begin
        if (!bus.Run) begin
          w_state_nxt   = ST_IDLE;
          w_running_nxt = 1'b0;
        end else if (bus.Speed != r_speed) begin
          // A rate change restarts the period and suppresses the pulse on that edge.
          w_count_nxt = div_m1(bus.Speed);
          w_speed_nxt = bus.Speed;
        end else if (r_count == '0) begin
          w_enable_nxt = 1'b1;
          w_count_nxt  = div_m1(r_speed);
        end else begin
          w_count_nxt = r_count - 1'b1;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_running_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_speed   <= 2'b00;
      r_enable  <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_speed   <= w_speed_nxt;
      r_enable  <= w_enable_nxt;
      r_running <= w_running_nxt;
    end
  end

  assign bus.Enable  = r_enable;
  assign bus.Running = r_running;
  assign bus.State   = (r_state == ST_COUNT);

endmodule
